cordic_shift_unit: RTL

CORDIC_SHIFT_UNIT -- requirements
Module: cordic_shift_unit

---
 rtl/cordic_pkg.sv | 14 +
 rtl/cordic_shift_stage.sv | 89 ++++++++
 rtl/cordic_shift_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC barrel-shift pipeline: shift-mode
// encoding and the default datapath width.
package cordic_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    SM_ASR     = 2'b00,
    SM_LSR     = 2'b01,
    SM_LSL_SAT = 2'b10,
    SM_ASR_RND = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/cordic_shift_stage.sv
// One pipeline stage: conditionally shifts by SHIFT (a power of two) and
// registers the result with its travelling mode/shamt/sign/guard/sat sideband.
module cordic_shift_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH),
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  shift_mode_t      in_mode,
  input  logic             in_sign,
  input  logic             in_guard,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output shift_mode_t      out_mode,
  output logic             out_sign,
  output logic             out_guard,
  output logic             out_sat
);

  localparam int BIT = $clog2(SHIFT);

  logic             load;
  logic             do_shift;
  logic [WIDTH-1:0] shifted;
  logic             guard_n;
  logic             sat_n;

  // Handshake: a word moves on a clock edge where valid && ready. The stage
  // reloads whenever it is empty or its content is leaving, so bubbles collapse.
  assign load     = !out_valid || out_ready;
  assign in_ready = load;
  assign do_shift = in_shamt[BIT];

  always_comb begin
    shifted = in_data;
    guard_n = in_guard;
    sat_n   = in_sat;
    if (do_shift) begin
      case (in_mode)
        SM_ASR, SM_ASR_RND: begin
          shifted = $signed(in_data) >>> SHIFT;
          guard_n = in_data[SHIFT-1];
        end
        SM_LSR: begin
          shifted = in_data >> SHIFT;
          guard_n = in_data[SHIFT-1];
        end
        default: begin
          shifted = in_data << SHIFT;
          // Every dropped bit plus the new MSB must still equal the operand sign.
          if (in_data[WIDTH-1 -: SHIFT+1] != {(SHIFT+1){in_sign}}) sat_n = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_mode  <= SM_ASR;
      out_sign  <= 1'b0;
      out_guard <= 1'b0;
      out_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= shifted;
        out_shamt <= in_shamt;
        out_mode  <= in_mode;
        out_sign  <= in_sign;
        out_guard <= guard_n;
        out_sat   <= sat_n;
      end
    end
  end

endmodule

// File: rtl/cordic_shift_unit.sv
// Pipelined shifter (ASR, LSR, saturating LSL, rounded ASR) built from
// $clog2(WIDTH) binary-weighted stages with valid/ready flow control.
module cordic_shift_unit
  import cordic_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  logic             valid_a [0:SHW];
  logic             ready_a [0:SHW];
  logic [WIDTH-1:0] data_a  [0:SHW];
  logic [SHW-1:0]   shamt_a [0:SHW];
  shift_mode_t      mode_a  [0:SHW];
  logic             sign_a  [0:SHW];
  logic             guard_a [0:SHW];
  logic             sat_a   [0:SHW];

  assign valid_a[0] = in_valid;
  assign in_ready   = ready_a[0];
  assign data_a[0]  = in_data;
  assign shamt_a[0] = in_shamt;
  assign mode_a[0]  = shift_mode_t'(in_mode);
  assign sign_a[0]  = in_data[WIDTH-1];
  assign guard_a[0] = 1'b0;
  assign sat_a[0]   = 1'b0;

  assign ready_a[SHW] = out_ready;
  assign out_valid    = valid_a[SHW];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    cordic_shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .SHIFT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_a[k]),
      .in_ready  (ready_a[k]),
      .in_data   (data_a[k]),
      .in_shamt  (shamt_a[k]),
      .in_mode   (mode_a[k]),
      .in_sign   (sign_a[k]),
      .in_guard  (guard_a[k]),
      .in_sat    (sat_a[k]),
      .out_valid (valid_a[k+1]),
      .out_ready (ready_a[k+1]),
      .out_data  (data_a[k+1]),
      .out_shamt (shamt_a[k+1]),
      .out_mode  (mode_a[k+1]),
      .out_sign  (sign_a[k+1]),
      .out_guard (guard_a[k+1]),
      .out_sat   (sat_a[k+1])
    );
  end

  // Finishing step on the final register: saturation pattern or round-half-up.
  // Driven purely from registered state, so it holds steady while stalled.
  always_comb begin
    out_data = data_a[SHW];
    out_sat  = 1'b0;
    if (mode_a[SHW] == SM_LSL_SAT && sat_a[SHW]) begin
      out_data = {sign_a[SHW], {(WIDTH-1){~sign_a[SHW]}}};
      out_sat  = 1'b1;
    end else if (mode_a[SHW] == SM_ASR_RND && shamt_a[SHW] != '0) begin
      out_data = data_a[SHW] + WIDTH'(guard_a[SHW]);
    end
  end

endmodule
